wb_cmd_initiator: RTL

Wishbone classic initiator that drives the same wb__* bus our gfx IP exposes as a responder. It converts a queued command stream (read/write, address, data, byte-select) into single Wishbone cycles, one outstanding at a time, and returns one response per command. It is used as an on-chip sequencer and test driver for Wishbone responders such as the framebuffer/register IP. A per-cycle timeout guarantees forward progress if a responder never acks.

---
 rtl/wb_cmd_initiator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_cmd_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : wb_cmd_initiator
//  Brief    : Wishbone classic initiator fed by a command FIFO; one bus cycle
//             outstanding, one response per command, per-cycle ack timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [31:0] rsp_dat,
  output logic        rsp_timeout,
  output logic [31:0] wb__adr,
  output logic [31:0] wb__dat_w,
  input  logic [31:0] wb__dat_r,
  output logic [3:0]  wb__sel,
  output logic        wb__cyc,
  output logic        wb__stb,
  output logic        wb__we,
  input  logic        wb__ack,
  output logic        busy
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_ptr_w:0]   c_depth    = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;

  logic               r_mem_we  [DEPTH];
  logic [31:0]        r_mem_adr [DEPTH];
  logic [31:0]        r_mem_dat [DEPTH];
  logic [3:0]         r_mem_sel [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_empty;

  // Ready comes from the registered count only; a pop on the same edge does
  // not open a slot early.
  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count != c_depth);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign busy      = !w_empty || (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_we[r_wr_ptr]  <= cmd_we;
      r_mem_adr[r_wr_ptr] <= cmd_adr;
      r_mem_dat[r_wr_ptr] <= cmd_dat;
      r_mem_sel[r_wr_ptr] <= cmd_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      wb__adr     <= '0;
      wb__dat_w   <= '0;
      wb__sel     <= '0;
      wb__we      <= 1'b0;
      wb__cyc     <= 1'b0;
      wb__stb     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_we      <= 1'b0;
      rsp_dat     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            wb__adr   <= r_mem_adr[r_rd_ptr];
            wb__dat_w <= r_mem_dat[r_rd_ptr];
            wb__sel   <= r_mem_sel[r_rd_ptr];
            wb__we    <= r_mem_we[r_rd_ptr];
            wb__cyc   <= 1'b1;
            wb__stb   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_BUS;
          end
        end
        S_BUS: begin
          // Ack is tested first so a late ack beats the timeout on the same edge.
          if (wb__ack) begin
            rsp_dat     <= wb__we ? 32'd0 : wb__dat_r;
            rsp_we      <= wb__we;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            wb__cyc     <= 1'b0;
            wb__stb     <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_cnt == c_cnt_last) begin
            rsp_dat     <= '0;
            rsp_we      <= wb__we;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            wb__cyc     <= 1'b0;
            wb__stb     <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
